// File: rtl/fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_if
// Valid/ready stream carrying words from fifo_rd_stream to a consumer.
//   valid  producer -> consumer   word present on data
//   data   producer -> consumer   DW-bit stream word
//   ready  consumer -> producer   word accepted when valid && ready
// Modports: master = producer (fifo_rd_stream), slave = consumer.
// -----------------------------------------------------------------------------
interface fifo_rd_stream_if #(
   parameter int DW = 8
);
   logic          valid;
   logic [DW-1:0] data;
   logic          ready;

   modport master (output valid, output data, input  ready);
   modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side engine for fifo_sync. Issues FIFO reads, absorbs the FIFO's
// one-cycle registered read latency in a 3-entry skid buffer and presents the
// words as a valid/ready stream at one word per cycle. The read enable
// depends only on registered state, so there is no combinational path from
// the consumer's ready back to fifo_en_r.
//
// Ports
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   clr         in   1   synchronous flush of this block and the FIFO
//   fifo_clr    out  1   copy of clr, wire to fifo_sync clear
//   fifo_en_r   out  1   FIFO read enable
//   fifo_data   in   DW  FIFO read data, valid the cycle after fifo_en_r
//   fifo_empty  in   1   FIFO empty flag
//   strm        master   output stream (valid/data/ready)
//   rd_cnt      out  16  words delivered (only with FIFO_RD_CNT_EN)
//
// Build option
//   FIFO_RD_CNT_EN  defined: adds the rd_cnt delivered-word counter port.
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   output logic            fifo_clr,
   output logic            fifo_en_r,
   input  logic [DW-1:0]   fifo_data,
   input  logic            fifo_empty,
   fifo_rd_stream_if.master strm
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [15:0]     rd_cnt
`endif
);

   logic [DW-1:0] buffer [3];
   logic [1:0]    head;
   logic [1:0]    tail;
   logic [1:0]    occ;
   logic          inflight;

   logic          capture;
   logic          deliver;
   logic [2:0]    pending;

   function automatic logic [1:0] wrap_inc(input logic [1:0] ptr);
      return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
   endfunction

   // A word in flight already owns a slot, so it counts against the space.
   assign pending   = {1'b0, occ} + {2'b00, inflight};
   assign fifo_clr  = clr;
   assign fifo_en_r = rst_n && !clr && !fifo_empty && (pending < 3'd3);

   assign capture    = inflight;
   assign deliver    = strm.valid && strm.ready;
   assign strm.valid = (occ != 2'd0);
   assign strm.data  = buffer[head];

   // NOTE: the buffer is reset explicitly so data reads 0 out of reset; a
   // memory with no reset would save flops but leave data undefined.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) buffer[i] <= '0;
         head     <= 2'd0;
         tail     <= 2'd0;
         occ      <= 2'd0;
         inflight <= 1'b0;
      end else if (clr) begin
         // The word returning from an earlier read is dropped with the rest.
         head     <= 2'd0;
         tail     <= 2'd0;
         occ      <= 2'd0;
         inflight <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so occ/head/tail updates are order independent.
         if (capture) begin
            buffer[tail] <= fifo_data;
            tail         <= wrap_inc(tail);
         end
         if (deliver) begin
            head <= wrap_inc(head);
         end
         occ      <= occ + {1'b0, capture} - {1'b0, deliver};
         inflight <= fifo_en_r;
      end
   end

`ifdef FIFO_RD_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt <= 16'd0;
      end else if (clr) begin
         rd_cnt <= 16'd0;
      end else if (deliver) begin
         rd_cnt <= rd_cnt + 16'd1;
      end
   end
`endif

endmodule
